// File: rtl/generador_senales_bus_pkg.sv
// ============================================================================
// generador_senales_bus_pkg -- shared FSM states, phases and idle bus values
// Revision: 1.0
// ============================================================================
`default_nettype none

package generador_senales_bus_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ACTIVO = 2'd1,
    FIN    = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    BUS_CERO      = 2'd0,
    BUS_DIRECCION = 2'd1,
    BUS_DATO      = 2'd2
  } fuente_bus_t;

  localparam logic [3:0] FASE_0  = 4'd0;
  localparam logic [3:0] FASE_1  = 4'd1;
  localparam logic [3:0] FASE_2  = 4'd2;
  localparam logic [3:0] FASE_3  = 4'd3;
  localparam logic [3:0] FASE_4  = 4'd4;
  localparam logic [3:0] FASE_5  = 4'd5;
  localparam logic [3:0] FASE_6  = 4'd6;
  localparam logic [3:0] FASE_7  = 4'd7;
  localparam logic [3:0] FASE_8  = 4'd8;
  localparam logic [3:0] FASE_9  = 4'd9;
  localparam logic [3:0] FASE_10 = 4'd10;
  localparam logic [3:0] FASE_11 = 4'd11;

  localparam logic IDLE_CS_N   = 1'b1;
  localparam logic IDLE_RD_N   = 1'b1;
  localparam logic IDLE_WR_N   = 1'b1;
  localparam logic IDLE_AD     = 1'b1;
  localparam logic IDLE_BUS_OE = 1'b0;

  typedef struct packed {
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic        ad;
    logic        bus_oe;
    fuente_bus_t fuente;
  } control_t;

  localparam control_t CONTROL_IDLE = '{
    cs_n:   IDLE_CS_N,
    rd_n:   IDLE_RD_N,
    wr_n:   IDLE_WR_N,
    ad:     IDLE_AD,
    bus_oe: IDLE_BUS_OE,
    fuente: BUS_CERO
  };

  // Pin levels for one phase of an active transaction; phases 4 and 8..11
  // look exactly like the idle bus.
  function automatic control_t decodificar_fase(input logic [3:0] fase,
                                                input logic       escritura);
    control_t ctl;
    ctl = CONTROL_IDLE;
    case (fase)
      FASE_0: begin
        ctl.ad     = 1'b0;
        ctl.bus_oe = 1'b1;
        ctl.fuente = BUS_DIRECCION;
      end
      FASE_1, FASE_3: begin
        ctl.cs_n   = 1'b0;
        ctl.ad     = 1'b0;
        ctl.bus_oe = 1'b1;
        ctl.fuente = BUS_DIRECCION;
      end
      FASE_2: begin
        ctl.cs_n   = 1'b0;
        ctl.wr_n   = 1'b0;
        ctl.ad     = 1'b0;
        ctl.bus_oe = 1'b1;
        ctl.fuente = BUS_DIRECCION;
      end
      FASE_5, FASE_7: begin
        ctl.cs_n   = 1'b0;
        ctl.bus_oe = escritura;
        ctl.fuente = BUS_DATO;
      end
      FASE_6: begin
        ctl.cs_n   = 1'b0;
        ctl.bus_oe = escritura;
        ctl.fuente = BUS_DATO;
        if (escritura) begin
          ctl.wr_n = 1'b0;
        end else begin
          ctl.rd_n = 1'b0;
        end
      end
      default: ctl = CONTROL_IDLE;
    endcase
    return ctl;
  endfunction

endpackage

`default_nettype wire

// File: rtl/generador_senales_bus_sincronizador_bus.sv
// ============================================================================
// sincronizador_bus -- optional 2-flop synchronizer for the pad bus value
// (SINCRONIZADOR_BUS_EN); without it the module is a plain wire, no clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sincronizador_bus #(
  parameter int ANCHO = 8
) (
`ifdef SINCRONIZADOR_BUS_EN
  input  logic             clk,
  input  logic             reset,
`endif
  input  logic [ANCHO-1:0] bus_in,
  output logic [ANCHO-1:0] bus_sinc
);

`ifdef SINCRONIZADOR_BUS_EN
  logic [ANCHO-1:0] r_etapa_1;
  logic [ANCHO-1:0] r_etapa_2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_etapa_1 <= '0;
      r_etapa_2 <= '0;
    end else begin
      r_etapa_1 <= bus_in;
      r_etapa_2 <= r_etapa_1;
    end
  end

  assign bus_sinc = r_etapa_2;
`else
  assign bus_sinc = bus_in;
`endif

endmodule

`default_nettype wire

// File: rtl/generador_senales_bus.sv
// ============================================================================
// generador_senales_bus -- phase-driven multiplexed address/data bus master.
// Optional input synchronizer selected with macro SINCRONIZADOR_BUS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module generador_senales_bus
  import generador_senales_bus_pkg::*;
#(
  parameter int ANCHO_BUS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           c_5,
  input  logic                 enable_inicio,
  input  logic                 enable_escribir,
  input  logic                 enable_leer,
  input  logic [ANCHO_BUS-1:0] direccion,
  input  logic [ANCHO_BUS-1:0] dato_escribir,
  input  logic [ANCHO_BUS-1:0] bus_in,
  output logic                 cs_n,
  output logic                 rd_n,
  output logic                 wr_n,
  output logic                 ad,
  output logic [ANCHO_BUS-1:0] bus_out,
  output logic                 bus_oe,
  output logic [ANCHO_BUS-1:0] dato_leido,
  output logic                 dato_valido,
  output logic                 listo
);

  estado_t              r_estado;
  estado_t              w_estado_sig;
  logic [3:0]           r_fase_prev;
  logic [ANCHO_BUS-1:0] r_direccion;
  logic [ANCHO_BUS-1:0] r_dato;
  logic                 r_escritura;

  logic [ANCHO_BUS-1:0] w_bus_muestra;
  logic [ANCHO_BUS-1:0] w_bus_out_sig;
  logic                 w_alguna;
  logic                 w_escritura_req;
  logic                 w_escritura_act;
  logic                 w_fase_valida;
  logic                 w_paso_ok;
  logic                 w_cierre;
  logic                 w_inicio;
  logic                 w_captura;
  control_t             w_control;

  sincronizador_bus #(
    .ANCHO(ANCHO_BUS)
  ) u_sincronizador (
`ifdef SINCRONIZADOR_BUS_EN
    .clk      (clk),
    .reset    (reset),
`endif
    .bus_in   (bus_in),
    .bus_sinc (w_bus_muestra)
  );

  assign w_alguna        = enable_inicio | enable_escribir | enable_leer;
  assign w_escritura_req = enable_inicio | enable_escribir;
  assign w_fase_valida   = (c_5 <= FASE_11);
  assign w_paso_ok       = (c_5 == r_fase_prev) || (c_5 == r_fase_prev + 4'd1);
  assign w_cierre        = (r_fase_prev == FASE_11) && (c_5 == FASE_0);

  // Any irregular counter step or a dropped request abandons the transaction.
  always_comb begin
    w_estado_sig = r_estado;
    w_inicio     = 1'b0;
    w_captura    = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (w_alguna && (c_5 == FASE_0)) begin
          w_estado_sig = ACTIVO;
          w_inicio     = 1'b1;
        end
      end
      ACTIVO: begin
        if (!w_alguna || !w_fase_valida) begin
          w_estado_sig = REPOSO;
        end else if (w_cierre) begin
          w_estado_sig = FIN;
        end else if (!w_paso_ok) begin
          w_estado_sig = REPOSO;
        end else begin
          w_captura = !r_escritura && (r_fase_prev == FASE_6) && (c_5 == FASE_7);
        end
      end
      FIN: begin
        w_estado_sig = REPOSO;
      end
      default: begin
        w_estado_sig = REPOSO;
      end
    endcase
  end

  always_comb begin
    w_escritura_act = w_inicio ? w_escritura_req : r_escritura;
    w_control       = CONTROL_IDLE;
    if (w_estado_sig == ACTIVO) begin
      w_control = decodificar_fase(c_5, w_escritura_act);
    end
    w_bus_out_sig = '0;
    case (w_control.fuente)
      BUS_DIRECCION: w_bus_out_sig = w_inicio ? direccion : r_direccion;
      BUS_DATO:      w_bus_out_sig = r_dato;
      default:       w_bus_out_sig = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado    <= REPOSO;
      r_fase_prev <= FASE_0;
      r_direccion <= '0;
      r_dato      <= '0;
      r_escritura <= 1'b0;
      cs_n        <= IDLE_CS_N;
      rd_n        <= IDLE_RD_N;
      wr_n        <= IDLE_WR_N;
      ad          <= IDLE_AD;
      bus_oe      <= IDLE_BUS_OE;
      bus_out     <= '0;
      dato_leido  <= '0;
      dato_valido <= 1'b0;
      listo       <= 1'b0;
    end else begin
      r_estado    <= w_estado_sig;
      r_fase_prev <= c_5;
      if (w_inicio) begin
        r_direccion <= direccion;
        r_dato      <= dato_escribir;
        r_escritura <= w_escritura_req;
      end
      cs_n        <= w_control.cs_n;
      rd_n        <= w_control.rd_n;
      wr_n        <= w_control.wr_n;
      ad          <= w_control.ad;
      bus_oe      <= w_control.bus_oe;
      bus_out     <= w_bus_out_sig;
      listo       <= (w_estado_sig == FIN);
      dato_valido <= (w_estado_sig == FIN) && !r_escritura;
      if (w_captura) begin
        dato_leido <= w_bus_muestra;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_generador_senales_bus.sv
// ============================================================================
// tb_generador_senales_bus -- vector table, corner sequences, random vs model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_generador_senales_bus;

  localparam logic [6:0] IDLE = 7'b1111000;  // {cs,rd,wr,ad,oe,listo,valido}

  logic       clk;
  logic       reset;
  logic [3:0] c_5;
  logic       enable_inicio, enable_escribir, enable_leer;
  logic [7:0] direccion, dato_escribir, bus_in;
  logic       cs_n, rd_n, wr_n, ad, bus_oe, dato_valido, listo;
  logic [7:0] bus_out, dato_leido;

  int total;
  int bad;

  bit         m_act, m_fin, m_wr;
  int         m_prev;
  logic [7:0] m_dir, m_dato, m_leido;
  logic [6:0] exp_ctl;
  logic [7:0] exp_bus;

  typedef struct {
    logic [3:0] c;
    logic [2:0] en;
    logic [6:0] ctl;
    logic [7:0] bus;
  } vec_t;

  vec_t tabla [14];

  generador_senales_bus #(.ANCHO_BUS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .c_5             (c_5),
    .enable_inicio   (enable_inicio),
    .enable_escribir (enable_escribir),
    .enable_leer     (enable_leer),
    .direccion       (direccion),
    .dato_escribir   (dato_escribir),
    .bus_in          (bus_in),
    .cs_n            (cs_n),
    .rd_n            (rd_n),
    .wr_n            (wr_n),
    .ad              (ad),
    .bus_out         (bus_out),
    .bus_oe          (bus_oe),
    .dato_leido      (dato_leido),
    .dato_valido     (dato_valido),
    .listo           (listo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  function automatic logic [6:0] ctl_act();
    return {cs_n, rd_n, wr_n, ad, bus_oe, listo, dato_valido};
  endfunction

  task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nombre, got, exp, $time);
    end
  endtask

  // en = {enable_inicio, enable_escribir, enable_leer}
  task automatic ciclo(input logic [3:0] c, input logic [2:0] en,
                       input logic [7:0] d, input logic [7:0] dw, input logic [7:0] bi);
    c_5 = c;
    {enable_inicio, enable_escribir, enable_leer} = en;
    direccion = d;
    dato_escribir = dw;
    bus_in = bi;
    @(posedge clk);
    #1;
  endtask

  // Expected pins for phase f, straight from the phase map.
  function automatic void esperado(input int f, input bit w, input logic [7:0] a,
                                   input logic [7:0] dd, output logic [6:0] c,
                                   output logic [7:0] b);
    bit cs, rd, wr, adv, oe;
    cs  = !(f inside {1, 2, 3, 5, 6, 7});
    adv = (f >= 4);
    oe  = (f <= 3) || ((f >= 5) && (f <= 7) && w);
    wr  = !((f == 2) || ((f == 6) && w));
    rd  = !((f == 6) && !w);
    b   = (f <= 3) ? a : (((f >= 5) && (f <= 7)) ? dd : 8'h00);
    c   = {cs, rd, wr, adv, oe, 2'b00};
  endfunction

  task automatic modelo_paso();
    bit any, fin_now;
    int f, c;
    c = int'(c_5);
    any = enable_inicio | enable_escribir | enable_leer;
    f = -1;
    fin_now = 1'b0;
    if (!m_fin) begin
      if (m_act) begin
        if (!any || c > 11) begin
          m_act = 1'b0;
        end else if (m_prev == 11 && c == 0) begin
          m_act = 1'b0;
          fin_now = 1'b1;
        end else if (c == m_prev || c == m_prev + 1) begin
          f = c;
          if (!m_wr && m_prev == 6 && c == 7) m_leido = bus_in;
        end else begin
          m_act = 1'b0;
        end
      end else if (any && c == 0) begin
        m_act  = 1'b1;
        m_wr   = enable_inicio | enable_escribir;
        m_dir  = direccion;
        m_dato = dato_escribir;
        f = 0;
      end
    end
    m_fin  = fin_now;
    m_prev = c;
    if (f >= 0) begin
      esperado(f, m_wr, m_dir, m_dato, exp_ctl, exp_bus);
    end else begin
      exp_ctl = IDLE;
      exp_bus = 8'h00;
    end
    exp_ctl[1] = fin_now;
    exp_ctl[0] = fin_now && !m_wr;
  endtask

  initial begin
    int rc;
    logic [2:0] ren, en_now;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    c_5 = 4'd0;
    {enable_inicio, enable_escribir, enable_leer} = 3'b000;
    direccion = 8'h00;
    dato_escribir = 8'h00;
    bus_in = 8'h00;

    tabla[0]  = '{4'd0,  3'b010, 7'b1110100, 8'h21};
    tabla[1]  = '{4'd1,  3'b010, 7'b0110100, 8'h21};
    tabla[2]  = '{4'd2,  3'b010, 7'b0100100, 8'h21};
    tabla[3]  = '{4'd3,  3'b010, 7'b0110100, 8'h21};
    tabla[4]  = '{4'd4,  3'b010, 7'b1111000, 8'h00};
    tabla[5]  = '{4'd5,  3'b010, 7'b0111100, 8'h5A};
    tabla[6]  = '{4'd6,  3'b010, 7'b0101100, 8'h5A};
    tabla[7]  = '{4'd7,  3'b010, 7'b0111100, 8'h5A};
    tabla[8]  = '{4'd8,  3'b010, 7'b1111000, 8'h00};
    tabla[9]  = '{4'd9,  3'b010, 7'b1111000, 8'h00};
    tabla[10] = '{4'd10, 3'b010, 7'b1111000, 8'h00};
    tabla[11] = '{4'd11, 3'b010, 7'b1111000, 8'h00};
    tabla[12] = '{4'd0,  3'b010, 7'b1111010, 8'h00};
    tabla[13] = '{4'd1,  3'b000, 7'b1111000, 8'h00};

    @(posedge clk);
    #1;
    chk("reset ctl", {25'd0, ctl_act()}, {25'd0, IDLE});
    chk("reset bus_out", {24'd0, bus_out}, 32'h0);
    chk("reset dato_leido", {24'd0, dato_leido}, 32'h0);
    reset = 1'b1;
    ciclo(4'd5, 3'b000, 8'h00, 8'h00, 8'h00);

    // Write transaction vector table
    for (int i = 0; i < 14; i++) begin
      ciclo(tabla[i].c, tabla[i].en, 8'h21, 8'h5A, 8'hEE);
      chk($sformatf("escritura fila %0d", i), {17'd0, ctl_act(), bus_out},
          {17'd0, tabla[i].ctl, tabla[i].bus});
    end

    // Read transaction with capture on the 6->7 edge
    for (int p = 0; p < 12; p++) begin
      ciclo(4'(p), 3'b001, 8'h44, 8'h99, (p == 6 || p == 7) ? 8'hC3 : 8'h0F);
      chk($sformatf("lectura rd_n fase %0d", p), {31'd0, rd_n}, {31'd0, !(p == 6)});
      if (p >= 4) chk($sformatf("lectura bus_oe fase %0d", p), {31'd0, bus_oe}, 32'd0);
      if (p <= 3) chk($sformatf("lectura bus_out fase %0d", p), {24'd0, bus_out}, 32'h44);
    end
    ciclo(4'd0, 3'b001, 8'h44, 8'h99, 8'h0F);
    chk("lectura listo/valido", {30'd0, listo, dato_valido}, 32'd3);
    chk("lectura dato_leido", {24'd0, dato_leido}, 32'hC3);
    ciclo(4'd1, 3'b000, 8'h00, 8'h00, 8'h0F);
    chk("lectura pulso unico", {30'd0, listo, dato_valido}, 32'd0);

    // Abort by dropping the request in phase 6
    for (int p = 0; p < 6; p++) ciclo(4'(p), 3'b010, 8'h11, 8'h22, 8'h00);
    ciclo(4'd6, 3'b000, 8'h11, 8'h22, 8'h00);
    chk("aborto idle", {17'd0, ctl_act(), bus_out}, {17'd0, IDLE, 8'h00});
    for (int p = 7; p < 14; p++) begin
      ciclo(4'(p % 12), 3'b000, 8'h11, 8'h22, 8'h00);
      chk($sformatf("aborto sin listo %0d", p), {31'd0, listo}, 32'd0);
    end

    // Asynchronous reset during phase 2
    for (int p = 0; p < 3; p++) ciclo(4'(p), 3'b010, 8'h33, 8'h44, 8'h00);
    chk("reset previo wr_n", {31'd0, wr_n}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("reset async ctl", {17'd0, ctl_act(), bus_out}, {17'd0, IDLE, 8'h00});
    chk("reset async dato_leido", {24'd0, dato_leido}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ciclo(4'd3, 3'b010, 8'h33, 8'h44, 8'h00);
    chk("reset queda en reposo", {17'd0, ctl_act(), bus_out}, {17'd0, IDLE, 8'h00});

    // Illegal counter sequences: 3->7 and out-of-range 13
    ciclo(4'd0, 3'b010, 8'h77, 8'h88, 8'h00);
    chk("nueva direccion tras reset", {24'd0, bus_out}, 32'h77);
    for (int p = 1; p < 4; p++) ciclo(4'(p), 3'b010, 8'h77, 8'h88, 8'h00);
    ciclo(4'd7, 3'b010, 8'h77, 8'h88, 8'h00);
    chk("salto 3->7", {17'd0, ctl_act(), bus_out}, {17'd0, IDLE, 8'h00});
    ciclo(4'd8, 3'b010, 8'h77, 8'h88, 8'h00);
    chk("salto sigue reposo", {17'd0, ctl_act(), bus_out}, {17'd0, IDLE, 8'h00});
    ciclo(4'd0, 3'b010, 8'h77, 8'h88, 8'h00);
    ciclo(4'd1, 3'b010, 8'h77, 8'h88, 8'h00);
    ciclo(4'd13, 3'b010, 8'h77, 8'h88, 8'h00);
    chk("fase 13", {17'd0, ctl_act(), bus_out}, {17'd0, IDLE, 8'h00});
    ciclo(4'd0, 3'b000, 8'h77, 8'h88, 8'h00);
    chk("fase 13 sin listo", {31'd0, listo}, 32'd0);

    // Read and write both requested: write mode wins
    for (int p = 0; p < 12; p++) begin
      ciclo(4'(p), 3'b011, 8'h05, 8'h06, 8'hFF);
      chk($sformatf("prioridad rd_n fase %0d", p), {31'd0, rd_n}, 32'd1);
      if (p == 6) chk("prioridad wr_n fase 6", {31'd0, wr_n}, 32'd0);
      if (p == 6) chk("prioridad bus_out fase 6", {24'd0, bus_out}, 32'h06);
    end
    ciclo(4'd0, 3'b011, 8'h05, 8'h06, 8'hFF);
    chk("prioridad listo sin valido", {30'd0, listo, dato_valido}, 32'd2);
    ciclo(4'd1, 3'b000, 8'h05, 8'h06, 8'hFF);

    // Randomized traffic against the reference model
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_act = 1'b0;
    m_fin = 1'b0;
    m_wr = 1'b0;
    m_prev = 0;
    m_leido = 8'h00;
    m_dir = 8'h00;
    m_dato = 8'h00;
    rc = 0;
    ren = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 80) rc = (rc + 1) % 12;
      else if (r >= 95) rc = int'($urandom_range(0, 15));
      if (rc == 0) ren = 3'($urandom_range(0, 7));
      en_now = ($urandom_range(0, 99) < 2) ? 3'b000 : ren;
      c_5 = 4'(rc);
      {enable_inicio, enable_escribir, enable_leer} = en_now;
      direccion = 8'($urandom);
      dato_escribir = 8'($urandom);
      bus_in = 8'($urandom);
      modelo_paso();
      @(posedge clk);
      #1;
      chk("aleatorio salidas", {17'd0, ctl_act(), bus_out}, {17'd0, exp_ctl, exp_bus});
      chk("aleatorio dato_leido", {24'd0, dato_leido}, {24'd0, m_leido});
      chk("aleatorio strobes exclusivos", {31'd0, rd_n | wr_n}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/generador_senales_bus.md
GENERADOR_SENALES_BUS -- requirements
Module: generador_senales_bus

Interface
REQ-001 SHALL have parameter ANCHO_BUS, default 8: width of the multiplexed address/data bus.
REQ-002 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port c_5, input, 4: phase index 0..11 from the timing counter.
REQ-005 SHALL have ports enable_inicio, enable_escribir, enable_leer, input, 1 each: transaction requests.
REQ-006 SHALL have ports direccion and dato_escribir, input, ANCHO_BUS: address and write data.
REQ-007 SHALL have port bus_in, input, ANCHO_BUS: bus value seen at the pad.
REQ-008 SHALL have ports cs_n, rd_n, wr_n, ad, output, 1 each: chip select, read strobe, write strobe, address(0)/data(1) select.
REQ-009 SHALL have ports bus_out, output, ANCHO_BUS, and bus_oe, output, 1: pad drive value and enable.
REQ-010 SHALL have ports dato_leido, output, ANCHO_BUS; dato_valido, output, 1; listo, output, 1.

Function
REQ-011 SHALL run a 3-state FSM: REPOSO, ACTIVO, FIN.
REQ-012 REPOSO->ACTIVO SHALL occur when any enable is high and c_5==0; direccion, dato_escribir and mode are latched on that edge.
REQ-013 Mode SHALL be write when enable_escribir or enable_inicio is high; read only when enable_leer is the sole request.
REQ-014 In ACTIVO, all outputs SHALL be registered from the current c_5 (one-cycle latency).
REQ-015 Phase map: 0: ad=0, bus_oe=1, bus_out=address; 1: adds cs_n=0; 2: adds wr_n=0; 3: wr_n=1, cs_n=0; 4: ad=1, cs_n=1, bus_oe=0.
REQ-016 Phase map: 5: ad=1, cs_n=0, bus_oe=write, bus_out=write data; 6: as 5 plus rd_n=0 (read) or wr_n=0 (write); 7: strobes released, cs_n=0; 8..11: cs_n=1, bus_oe=0, ad=1.
REQ-017 On the edge where c_5 goes 6->7 in read mode, dato_leido SHALL load the sampled bus_in.
REQ-018 On c_5 11->0 in ACTIVO, SHALL go to FIN; FIN asserts listo for exactly one cycle, plus dato_valido if read, then returns to REPOSO.
REQ-019 Back-to-back requests SHALL restart from REPOSO on the following cycle; no phase-0 merging.
REQ-020 All enables low in ACTIVO SHALL abort: REPOSO next edge, idle outputs, no listo.
REQ-021 Any c_5 step other than hold or +1 (except 11->0), or c_5>11, SHALL abort as in REQ-020.
REQ-022 Idle outputs: cs_n=1, rd_n=1, wr_n=1, ad=1, bus_oe=0, bus_out=0; rd_n and wr_n SHALL never be low simultaneously.

Reset
REQ-023 reset low SHALL immediately force REPOSO, idle outputs, dato_leido=0, dato_valido=0, listo=0.
REQ-024 Reset mid-transaction SHALL discard latched address, data and mode.

Configuration
REQ-025 With SINCRONIZADOR_BUS_EN defined, bus_in SHALL pass a 2-flop synchronizer before capture (capture still on 6->7 edge).
REQ-026 Without SINCRONIZADOR_BUS_EN, bus_in SHALL be captured directly.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the phase constants 0..11 and the idle output values.
REQ-028 A sub-module sincronizador_bus SHALL implement the optional synchronizer.

Verification
REQ-029 Write: enable_escribir=1, direccion=8'h21, dato_escribir=8'h5A, c_5 stepped 0..11 -> bus_out=8'h21 during phases 0-3, 8'h5A during 5-7, wr_n low in phases 2 and 6, one listo pulse.
REQ-030 Read: enable_leer=1, bus_in=8'hC3 during phase 6 -> rd_n low in phase 6 only, bus_oe=0 from phase 4, dato_leido=8'hC3, dato_valido and listo for one cycle.
REQ-031 Abort: enable_escribir drops in phase 6 -> idle outputs next edge, no listo.
REQ-032 Reset: reset low during phase 2 -> idle outputs immediately, dato_leido=0, REPOSO.
REQ-033 Bad sequence: c_5 jumps 3->7 -> abort; c_5=13 -> idle outputs.
REQ-034 Priority: enable_leer and enable_escribir both high -> write-mode transaction, rd_n stays 1.
